// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared codes, geometry and helpers for the pong ball logic
package pong_pkg;

  typedef enum logic [1:0] {
    GS_P1_SERVE = 2'd0,
    GS_P2_SERVE = 2'd1,
    GS_PLAYING  = 2'd2,
    GS_GAME_END = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_MOVE   = 2'd2,
    ST_FROZEN = 2'd3
  } ball_state_e;

  localparam logic [9:0] P1_BOARD_X = 10'd110;
  localparam logic [9:0] P2_BOARD_X = 10'd530;
  localparam logic [9:0] TOP_Y      = 10'd40;
  localparam logic [9:0] BOT_Y      = 10'd440;
  localparam logic [9:0] PAD_HALF   = 10'd30;
  localparam logic [9:0] PARK_GAP   = 10'd8;
  localparam logic [9:0] X_MAX      = 10'd639;
  localparam logic [9:0] RESET_Y    = 10'd240;
  localparam logic [9:0] P1_PARK_X  = P1_BOARD_X + PARK_GAP;
  localparam logic [9:0] P2_PARK_X  = P2_BOARD_X - PARK_GAP;
  localparam logic [2:0] SPEED_INIT = 3'd2;
  localparam logic [2:0] SPEED_MAX  = 3'd6;

  // Widened to 11 bits signed so a full-range difference never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 11'(-d) : 11'(d);
  endfunction

  function automatic ball_state_e leave_play(input game_state_e gs);
    return (gs == GS_GAME_END) ? ST_FROZEN : ST_PARK;
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one motion step along an axis with reflection at lo/hi
// dir=1 moves toward hi; reaching or crossing a bound snaps onto it and reverses.
module ball_axis_step (
  input  logic [9:0] pos,
  input  logic [2:0] step,
  input  logic       dir,
  input  logic [9:0] lo,
  input  logic [9:0] hi,
  output logic [9:0] next_pos,
  output logic       next_dir,
  output logic       bounced
);

  logic signed [11:0] np;

  always_comb begin
    np = dir ? $signed({2'b00, pos}) + $signed({9'b0, step})
             : $signed({2'b00, pos}) - $signed({9'b0, step});
    next_pos = np[9:0];
    next_dir = dir;
    bounced  = 1'b0;
    if (dir && np >= $signed({2'b00, hi})) begin
      next_pos = hi;
      next_dir = 1'b0;
      bounced  = 1'b1;
    end else if (!dir && np <= $signed({2'b00, lo})) begin
      next_pos = lo;
      next_dir = 1'b1;
      bounced  = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - ball park/launch/move/freeze sequencing for pong
// BALL_SPEEDUP_EN: each paddle return raises the x step by one up to SPEED_MAX.
module ball_motion_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] game_state,
  input  logic [9:0] p1_pad_y,
  input  logic [9:0] p2_pad_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit_p1,
  output logic       hit_p2,
  output logic       wall_bounce
);

  localparam logic signed [11:0] P1_S   = $signed({2'b00, P1_BOARD_X});
  localparam logic signed [11:0] P2_S   = $signed({2'b00, P2_BOARD_X});
  localparam logic signed [11:0] XMAX_S = $signed({2'b00, X_MAX});

  ball_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  speed_q, speed_d, speed_up;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        serve_p2_q, serve_p2_d;
  logic        hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d, wall_q, wall_d;

  game_state_e        gs;
  logic signed [11:0] nx;
  logic [9:0]         y_step;
  logic               dir_y_step, y_bounced;
  logic               p1_cross, p2_cross, p1_cover, p2_cover;

  assign gs = game_state_e'(game_state);
  assign nx = dir_x_q ? $signed({2'b00, x_q}) + $signed({9'b0, speed_q})
                      : $signed({2'b00, x_q}) - $signed({9'b0, speed_q});

  assign p1_cross = !dir_x_q && (x_q > P1_BOARD_X) && (nx <= P1_S);
  assign p2_cross =  dir_x_q && (x_q < P2_BOARD_X) && (nx >= P2_S);
  assign p1_cover = abs_diff(y_q, p1_pad_y) <= {1'b0, PAD_HALF};
  assign p2_cover = abs_diff(y_q, p2_pad_y) <= {1'b0, PAD_HALF};

`ifdef BALL_SPEEDUP_EN
  assign speed_up = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 3'd1;
`else
  assign speed_up = speed_q;
`endif

  ball_axis_step u_y_step (
    .pos      (y_q),
    .step     (3'd1),
    .dir      (dir_y_q),
    .lo       (TOP_Y),
    .hi       (BOT_Y),
    .next_pos (y_step),
    .next_dir (dir_y_step),
    .bounced  (y_bounced)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    speed_d    = speed_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    serve_p2_d = serve_p2_q;
    hit_p1_d   = 1'b0;
    hit_p2_d   = 1'b0;
    wall_d     = 1'b0;
    case (state_q)
      ST_PARK: begin
        case (gs)
          GS_P1_SERVE: begin x_d = P1_PARK_X; y_d = p1_pad_y; serve_p2_d = 1'b0; end
          GS_P2_SERVE: begin x_d = P2_PARK_X; y_d = p2_pad_y; serve_p2_d = 1'b1; end
          GS_PLAYING:  state_d = ST_LAUNCH;
          default:     state_d = ST_FROZEN;
        endcase
      end
      ST_LAUNCH: begin
        if (gs == GS_PLAYING) begin
          speed_d = SPEED_INIT;
          dir_x_d = !serve_p2_q;
          dir_y_d = 1'b1;
          state_d = ST_MOVE;
        end else begin
          state_d = leave_play(gs);
        end
      end
      ST_MOVE: begin
        if (gs != GS_PLAYING) begin
          state_d = leave_play(gs);
        end else if (tick) begin
          y_d     = y_step;
          dir_y_d = dir_y_step;
          wall_d  = y_bounced;
          // A paddle only catches the ball on the tick it crosses the face.
          if (p1_cross && p1_cover) begin
            x_d = P1_BOARD_X + 10'd1; dir_x_d = 1'b1; hit_p1_d = 1'b1; speed_d = speed_up;
          end else if (p2_cross && p2_cover) begin
            x_d = P2_BOARD_X - 10'd1; dir_x_d = 1'b0; hit_p2_d = 1'b1; speed_d = speed_up;
          end else if (nx < 0) begin
            x_d = 10'd0;
          end else if (nx > XMAX_S) begin
            x_d = X_MAX;
          end else begin
            x_d = nx[9:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PARK;
      x_q        <= P1_PARK_X;
      y_q        <= RESET_Y;
      speed_q    <= SPEED_INIT;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      serve_p2_q <= 1'b0;
      hit_p1_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
      wall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      speed_q    <= speed_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      serve_p2_q <= serve_p2_d;
      hit_p1_q   <= hit_p1_d;
      hit_p2_q   <= hit_p2_d;
      wall_q     <= wall_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign hit_p1      = hit_p1_q;
  assign hit_p2      = hit_p2_q;
  assign wall_bounce = wall_q;

endmodule
